// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester round-robin front end for a byte UART.
// The TX side grants one requester at a time and drives the UART start/value
// handshake. The RX side captures received bytes into a one-entry holding
// register, applying backpressure to the UART while that register is full.
// Optional feature: define UART_ARB_TIMEOUT_EN to abort a SEND that waits
// TIMEOUT_CYCLES cycles for uart_tx_done. An aborted SEND still completes the
// handshake with the requester, and the abort sets the sticky err_timeout flag.
module uart_tx_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_start,
  input  logic [7:0] req_value0,
  input  logic [7:0] req_value1,
  output logic [1:0] req_done,
  output logic       uart_start_tx,
  output logic [7:0] uart_tx_value,
  input  logic       uart_tx_done,
  input  logic       uart_rx_available,
  input  logic [7:0] uart_rx_value,
  output logic       uart_rx_clear,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ack,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    SEND     = 3'b010,
    COMPLETE = 3'b100
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   grant;
  logic   last_grant;
  logic   grant_nxt;
  logic   take_req;
  logic   timeout_hit;
  logic   rx_avail_p1;
  logic   rx_capture;

  // Contention goes to the requester that was not served last; a lone request wins outright.
  function automatic logic pick_grant(input logic [1:0] req, input logic last);
    logic g;
    if (req == 2'b11) g = ~last;
    else              g = req[1];
    return g;
  endfunction

  assign grant_nxt = pick_grant(req_start, last_grant);
  assign take_req  = (state == IDLE) && (|req_start);

  // TX state register; reset drops SEND at once, so uart_start_tx falls asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // TX next-state: COMPLETE holds until the UART and the served requester have both released.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (|req_start) state_nxt = SEND;
      SEND:     if (uart_tx_done || timeout_hit) state_nxt = COMPLETE;
      COMPLETE: if (!uart_tx_done && !req_start[grant]) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // TX outputs are decoded purely from the state so they cannot glitch on input changes.
  always_comb begin
    uart_start_tx = 1'b0;
    req_done      = 2'b00;
    case (state)
      SEND:     uart_start_tx   = 1'b1;
      COMPLETE: req_done[grant] = 1'b1;
      default:  uart_start_tx   = 1'b0;
    endcase
  end

  // Grant bookkeeping and the outgoing byte only move on the IDLE->SEND transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      uart_tx_value <= 8'h00;
    end else if (take_req) begin
      grant         <= grant_nxt;
      last_grant    <= grant_nxt;
      uart_tx_value <= grant_nxt ? req_value1 : req_value0;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        err_q;

  // The current cycle is the last allowed SEND cycle once the count plus this one reaches the limit.
  assign timeout_hit = (state == SEND) &&
                       (({1'b0, to_cnt} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});
  assign err_timeout = err_q;

  // SEND watchdog: cleared on entry, counts SEND cycles, flags an abort stickily.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      if (take_req)            to_cnt <= 16'd0;
      else if (state == SEND)  to_cnt <= to_cnt + 16'd1;
      if (timeout_hit && !uart_tx_done) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  // Without the watchdog the limit parameter has no consumer in this build.
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  // Capture on the second consecutive available cycle, so the UART's late value update has settled;
  // an active clear blocks recapture of the byte already taken.
  assign rx_capture = uart_rx_available && rx_avail_p1 && !rx_valid && !uart_rx_clear;

  // One-cycle history of uart_rx_available for the two-cycle qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_avail_p1 <= 1'b0;
    else     rx_avail_p1 <= uart_rx_available;
  end

  // Holding register plus UART clear handshake; a full register leaves the UART byte untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid      <= 1'b0;
      rx_data       <= 8'h00;
      uart_rx_clear <= 1'b0;
    end else begin
      if (rx_capture) begin
        rx_valid <= 1'b1;
        rx_data  <= uart_rx_value;
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (rx_capture)              uart_rx_clear <= 1'b1;
      else if (!uart_rx_available) uart_rx_clear <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: randomized requesters, UART stub and RX
// consumer, with a transaction-level model feeding scoreboard queues that an
// independent monitor drains as the DUT presents transfers and captures.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_start = 2'b00;
  logic [7:0] req_value0 = 8'h00;
  logic [7:0] req_value1 = 8'h00;
  logic [1:0] req_done;
  logic       uart_start_tx;
  logic [7:0] uart_tx_value;
  logic       uart_tx_done = 1'b0;
  logic       uart_rx_available = 1'b0;
  logic [7:0] uart_rx_value = 8'h00;
  logic       uart_rx_clear;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ack = 1'b0;
  logic       err_timeout;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_start         (req_start),
    .req_value0        (req_value0),
    .req_value1        (req_value1),
    .req_done          (req_done),
    .uart_start_tx     (uart_start_tx),
    .uart_tx_value     (uart_tx_value),
    .uart_tx_done      (uart_tx_done),
    .uart_rx_available (uart_rx_available),
    .uart_rx_value     (uart_rx_value),
    .uart_rx_clear     (uart_rx_clear),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .rx_ack            (rx_ack),
    .err_timeout       (err_timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic       g;
    logic [7:0] b;
  } tx_item_t;

  tx_item_t   tx_exp[$];
  logic [7:0] rx_exp[$];
  logic       model_last   = 1'b1;
  int         exp_send_len = 0;
  bit         stub_hang    = 1'b0;
  int         stub_fixed   = 0;
  int         ack_mode     = 0;

  // Requests raised together from an idle arbiter: served in round-robin order.
  task automatic model_push(input logic [1:0] mask, input logic [7:0] b0, input logic [7:0] b1);
    tx_item_t it;
    logic     first;
    if (mask == 2'b11) begin
      first = ~model_last;
      it.g = first;  it.b = first ? b1 : b0; tx_exp.push_back(it);
      it.g = ~first; it.b = first ? b0 : b1; tx_exp.push_back(it);
      model_last = ~first;
    end else if (mask != 2'b00) begin
      first = mask[1];
      it.g = first; it.b = first ? b1 : b0; tx_exp.push_back(it);
      model_last = first;
    end
  endtask

  // ---------------- monitor ----------------
  logic       cur_g = 1'b0;
  logic [7:0] held_val = 8'h00;
  bit         awaiting = 1'b0;
  int         send_len = 0;
  bit         prev_start = 1'b0;
  bit         prev_done = 1'b0;
  bit         prev_valid = 1'b0;
  bit         prev_clear = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial begin : monitor
    tx_item_t   it;
    logic [7:0] rx_e;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        awaiting = 1'b0; prev_start = 1'b0; prev_done = 1'b0; send_len = 0;
        prev_valid = 1'b0; prev_clear = 1'b0; prev_data = 8'h00;
      end else begin
        if (uart_start_tx && !prev_start) begin
          if (tx_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected: sent 0x%02h, expected no transfer", uart_tx_value);
          end else begin
            it = tx_exp.pop_front();
            check("tx_byte", uart_tx_value, it.b);
            cur_g = it.g;
          end
          check("tx_prev_done_seen", awaiting, 0);
          awaiting = 1'b1;
          held_val = uart_tx_value;
          send_len = 1;
        end else if (uart_start_tx) begin
          check("tx_value_stable", uart_tx_value, held_val);
          send_len++;
        end else if (prev_start && exp_send_len != 0) begin
          check("tx_send_len", send_len, exp_send_len);
        end
        if (req_done != 2'b00) begin
          if (!prev_done) check("req_done_expected", awaiting, 1);
          check("req_done_grant", req_done, 2'b01 << cur_g);
          check("req_done_vs_start", uart_start_tx, 0);
          awaiting = 1'b0;
        end
        if (rx_valid && !prev_valid) begin
          if (rx_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL rx_unexpected: captured 0x%02h, expected none", rx_data);
          end else begin
            rx_e = rx_exp.pop_front();
            check("rx_data", rx_data, rx_e);
          end
          check("rx_clear_on_capture", uart_rx_clear, 1);
        end
        if (prev_valid) begin
          if (rx_ack) check("rx_pop", rx_valid, 0);
          else begin
            check("rx_hold_valid", rx_valid, 1);
            check("rx_hold_data", rx_data, prev_data);
          end
        end
        if (uart_rx_clear && !prev_clear)
          check("rx_clear_only_with_capture", rx_valid && !prev_valid, 1);
        prev_start = uart_start_tx;
        prev_done  = (req_done != 2'b00);
        prev_valid = rx_valid;
        prev_clear = uart_rx_clear;
        prev_data  = rx_data;
      end
    end
  end

  // ---------------- UART TX stub ----------------
  initial begin : uart_stub
    int d, k, h;
    forever begin
      @(negedge clk);
      if (uart_start_tx && !stub_hang) begin
        d = (stub_fixed != 0) ? stub_fixed : $urandom_range(1, 12);
        k = 1;
        while (k < d && uart_start_tx && !stub_hang) begin @(negedge clk); k++; end
        if (uart_start_tx && !stub_hang) begin
          uart_tx_done = 1'b1;
          k = 0;
          while (uart_start_tx && k < 64) begin @(negedge clk); k++; end
          h = $urandom_range(0, 3);
          repeat (h) @(negedge clk);
          uart_tx_done = 1'b0;
        end
      end
    end
  end

  // ---------------- RX consumer ----------------
  initial begin : consumer
    forever begin
      @(negedge clk);
      case (ack_mode)
        0:       rx_ack = 1'b0;
        1:       rx_ack = 1'($urandom_range(0, 1));
        default: rx_ack = 1'b1;
      endcase
    end
  end

  task automatic set_ack_mode(input int m);
    @(posedge clk); #2 ack_mode = m;
  endtask

  // ---------------- stimulus tasks ----------------
  task automatic tx_round(input logic [1:0] mask, input logic [7:0] b0, input logic [7:0] b1);
    int n, hold0, hold1, seen0, seen1;
    model_push(mask, b0, b1);
    @(negedge clk);
    req_value0 = b0; req_value1 = b1; req_start = mask;
    hold0 = $urandom_range(0, 2); hold1 = $urandom_range(0, 2);
    seen0 = 0; seen1 = 0; n = 0;
    while ((req_start != 2'b00 || req_done != 2'b00) && n < 2000) begin
      @(negedge clk); n++;
      if (req_start[0] && req_done[0]) begin
        if (seen0 >= hold0) req_start[0] = 1'b0; else seen0++;
      end
      if (req_start[1] && req_done[1]) begin
        if (seen1 >= hold1) req_start[1] = 1'b0; else seen1++;
      end
    end
    check("tx_round_finished", (req_start == 2'b00) && (req_done == 2'b00), 1);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!uart_start_tx && n < 100) begin @(negedge clk); n++; end
    check(name, uart_start_tx, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1; req_start = 2'b00;
    #1;
    check("rst_start_tx", uart_start_tx, 0);
    check("rst_req_done", req_done, 0);
    check("rst_tx_value", uart_tx_value, 0);
    check("rst_rx_clear", uart_rx_clear, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_err_timeout", err_timeout, 0);
    model_last = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input int max_wait);
    int n, hold;
    rx_exp.push_back(b);
    @(negedge clk); uart_rx_available = 1'b1; uart_rx_value = ~b;
    @(negedge clk); uart_rx_value = b;
    n = 0;
    while (!uart_rx_clear && n < max_wait) begin @(negedge clk); n++; end
    check("rx_clear_seen", uart_rx_clear, 1);
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rx_clear_held", uart_rx_clear, 1);
    end
    uart_rx_available = 1'b0;
    @(negedge clk);
    check("rx_clear_drop", uart_rx_clear, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [7:0] b;
    int         n;

    repeat (3) @(negedge clk);
    check("init_start_tx", uart_start_tx, 0);
    check("init_req_done", req_done, 0);
    check("init_tx_value", uart_tx_value, 0);
    check("init_rx_valid", rx_valid, 0);
    check("init_rx_clear", uart_rx_clear, 0);
    check("init_err_timeout", err_timeout, 0);
    #1 rst = 1'b0;

    // Contention straight out of reset, then repeated contention
    tx_round(2'b11, 8'hA0, 8'hB1);
    for (int r = 0; r < 3; r++) tx_round(2'b11, 8'($urandom), 8'($urandom));

    // Single requester with a fixed 20-cycle UART
    stub_fixed = 20; exp_send_len = 20;
    tx_round(2'b01, 8'h55, 8'($urandom));
    check("single_idle_start", uart_start_tx, 0);
    check("single_idle_done", req_done, 0);
    exp_send_len = 0;

    // Requester withdraws during SEND: transfer still completes
    stub_fixed = 8;
    b = 8'($urandom);
    model_push(2'b10, 8'h00, b);
    @(negedge clk); req_value1 = b; req_start = 2'b10;
    wait_start("early_drop_start");
    @(negedge clk); req_start = 2'b00;
    n = 0;
    while (req_done != 2'b10 && n < 100) begin @(negedge clk); n++; end
    check("early_drop_done", req_done, 2'b10);
    n = 0;
    while (req_done != 2'b00 && n < 100) begin @(negedge clk); n++; end
    check("early_drop_release", req_done, 0);
    stub_fixed = 0;

    // Random mixed rounds
    for (int r = 0; r < 6; r++)
      tx_round(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom));

    // RX capture, clear handshake and pop
    rx_send(8'h3C, 20);
    check("rx_first_valid", rx_valid, 1);
    check("rx_first_data", rx_data, 8'h3C);
    set_ack_mode(2); set_ack_mode(0);
    check("rx_first_popped", rx_valid, 0);

    // Backpressure: full register holds, UART byte waits for the pop
    rx_send(8'h3C, 20);
    check("rx_bp_valid", rx_valid, 1);
    b = 8'($urandom);
    fork
      rx_send(b, 200);
      begin
        repeat (12) @(negedge clk);
        check("rx_bp_no_clear", uart_rx_clear, 0);
        check("rx_bp_keep_data", rx_data, 8'h3C);
        set_ack_mode(2); set_ack_mode(0);
      end
    join
    check("rx_bp_new_valid", rx_valid, 1);
    check("rx_bp_new_data", rx_data, b);

    // RX and TX traffic concurrently
    set_ack_mode(1);
    fork
      begin
        for (int r = 0; r < 10; r++)
          tx_round(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom));
      end
      begin
        for (int r = 0; r < 10; r++) begin
          rx_send(8'($urandom), 400);
          repeat ($urandom_range(0, 5)) @(negedge clk);
        end
      end
    join
    set_ack_mode(2);
    repeat (3) @(negedge clk);
    check("rx_drained", rx_valid, 0);

    // Reset in the middle of SEND, after requester 0 was last granted
    stub_hang = 1'b1;
    b = 8'($urandom);
    model_push(2'b01, b, 8'h00);
    @(negedge clk); req_value0 = b; req_start = 2'b01;
    wait_start("rst_mid_start");
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_start_tx", uart_start_tx, 0);
    check("rst_mid_req_done", req_done, 0);
    req_start = 2'b00; model_last = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    stub_hang = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", req_done, 0);
    tx_round(2'b11, 8'($urandom), 8'($urandom));

    // UART never answers
    stub_hang = 1'b1;
    b = 8'($urandom);
`ifdef UART_ARB_TIMEOUT_EN
    exp_send_len = 16;
    model_push(2'b01, b, 8'h00);
    @(negedge clk); req_value0 = b; req_start = 2'b01;
    n = 0;
    while (req_done != 2'b01 && n < 100) begin @(negedge clk); n++; end
    check("to_complete", req_done, 2'b01);
    check("to_err_set", err_timeout, 1);
    req_start = 2'b00;
    n = 0;
    while (req_done != 2'b00 && n < 100) begin @(negedge clk); n++; end
    check("to_release", req_done, 0);
    exp_send_len = 0;
    stub_hang = 1'b0;
    tx_round(2'b10, 8'($urandom), 8'($urandom));
    check("to_err_sticky", err_timeout, 1);
    do_reset();
`else
    model_push(2'b01, b, 8'h00);
    @(negedge clk); req_value0 = b; req_start = 2'b01;
    wait_start("persist_start");
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("persist_send", uart_start_tx, 1);
    end
    check("persist_no_done", req_done, 0);
    check("persist_no_err", err_timeout, 0);
    do_reset();
    stub_hang = 1'b0;
`endif
    tx_round(2'b11, 8'($urandom), 8'($urandom));

    repeat (5) @(negedge clk);
    check("tx_queue_empty", tx_exp.size(), 0);
    check("rx_queue_empty", rx_exp.size(), 0);
    check("tx_nothing_pending", awaiting, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached with checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000; cycles in SEND before abort (used only with UART_ARB_TIMEOUT_EN).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, all flops on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_start  in  2  per-requester level send request, held until req_done
- req_value0  in  8  requester 0 byte
- req_value1  in  8  requester 1 byte
- req_done  out  2  per-requester completion, level
- uart_start_tx  out  1  to UART start_tx
- uart_tx_value  out  8  to UART tx_value
- uart_tx_done  in  1  from UART tx_done
- uart_rx_available  in  1  from UART rx_available
- uart_rx_value  in  8  from UART rx_value
- uart_rx_clear  out  1  to UART rx_clear
- rx_valid  out  1  holding register full
- rx_data  out  8  holding register byte
- rx_ack  in  1  consumer pop
- err_timeout  out  1  sticky TX abort flag

Function
REQ-003 TX FSM SHALL have states IDLE, SEND, COMPLETE; one-hot encoded.
REQ-004 IDLE: any req_start bit high -> latch grant index g and its byte into uart_tx_value, go SEND next cycle.
REQ-005 Both requests high in same IDLE cycle SHALL grant the requester not granted last (round-robin); last_grant resets to 1, so requester 0 wins first contention.
REQ-006 SEND: uart_start_tx=1, uart_tx_value stable; uart_tx_done=1 -> COMPLETE.
REQ-007 COMPLETE: uart_start_tx=0, req_done[g]=1; return to IDLE only when uart_tx_done=0 and req_start[g]=0 in the same cycle.
REQ-008 req_done[~g] SHALL be 0 always; req_done[g] SHALL be 0 outside COMPLETE.
REQ-009 Request of the non-granted requester SHALL be held pending, unaffected, and served on next IDLE.
REQ-010 req_start[g] dropping during SEND SHALL NOT abort; transfer completes, req_done[g] asserts for one cycle minimum in COMPLETE.
REQ-011 uart_tx_value SHALL change only on IDLE->SEND transition.
REQ-012 RX: uart_rx_available high two consecutive cycles with rx_valid=0 -> capture uart_rx_value into rx_data, set rx_valid, assert uart_rx_clear (second-cycle capture covers UART's one-cycle rx_value update).
REQ-013 uart_rx_clear SHALL stay high until the first cycle uart_rx_available=0, then drop next cycle.
REQ-014 rx_valid=1 SHALL NOT assert uart_rx_clear; UART byte held (backpressure, no overwrite, no drop).
REQ-015 rx_valid & rx_ack clears rx_valid next cycle; rx_ack with rx_valid=0 ignored.
REQ-016 Pop and new capture in same cycle not possible; capture requires rx_valid=0 in the capture cycle.
REQ-017 RX and TX paths SHALL operate concurrently and independently.

Reset
REQ-018 rst high SHALL immediately: FSM=IDLE, last_grant=1, uart_start_tx=0, uart_tx_value=0, req_done=0, uart_rx_clear=0, rx_valid=0, rx_data=0, err_timeout=0, timeout counter=0.
REQ-019 rst mid-transfer SHALL drop uart_start_tx asynchronously; no req_done issued for the aborted byte.

Configuration
REQ-020 Macro UART_ARB_TIMEOUT_EN defined: 16-bit counter clears on entry to SEND, increments each SEND cycle; reaching TIMEOUT_CYCLES without uart_tx_done -> COMPLETE with req_done[g]=1 and err_timeout set sticky until rst.
REQ-021 Macro undefined: no counter; SEND waits indefinitely; err_timeout tied 0.

Verification
REQ-022 req_start=01, req_value0=8'h55, uart_tx_done high 20 cycles later -> uart_start_tx high 20 cycles with value 8'h55, req_done=01, IDLE after req_start drops.
REQ-023 req_start=11 from reset, values 8'hA0/8'hB1 -> bytes sent A0 then B1; repeat contention -> grant order alternates 0,1,0,1.
REQ-024 uart_rx_available high, rx_value 8'h3C from second cycle -> rx_data=8'h3C, rx_valid=1, uart_rx_clear high until available falls; rx_ack -> rx_valid=0.
REQ-025 rx_valid=1 unpopped, second uart_rx_available -> uart_rx_clear stays 0, rx_data keeps 8'h3C; after rx_ack, new byte captured.
REQ-026 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, uart_tx_done held 0 -> COMPLETE after 16 SEND cycles, err_timeout=1 until rst; without macro, SEND persists 1000 cycles.
REQ-027 rst asserted during SEND -> uart_start_tx=0 same cycle, req_done=00, first grant after release goes to requester 0.
